led_pattern_fsm: RTL and testbench

- Parametrised LED sequencer, successor to the fixed 4-LED rotating FSM.
- Drives N_LEDS one-hot or bounce patterns and advances on a programmable tick divider instead of every clock.
- Adds run/pause, direction, and a mode select.
- Sits between the board clock and the LED pins; configuration comes from switches or a register block.

---
 rtl/led_pattern_fsm.sv | 128 ++++++++++++
 tb/tb_led_pattern_fsm.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_fsm.sv
// Parametrised LED sequencer: rotate / bounce / fill / blink patterns advanced by a tick divider.
// Optional LED_FSM_PWM_EN adds a 4-bit global brightness input gating every LED through a 16-step PWM.
module led_pattern_fsm #(
  parameter  int N_LEDS    = 8,
  parameter  int DIV_W     = 24,
  parameter  int RESET_POS = 0,
  localparam int PW        = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              dir,
  input  logic [DIV_W-1:0]  div_load,
`ifdef LED_FSM_PWM_EN
  input  logic [3:0]        brightness,
`endif
  output logic              step,
  output logic [PW-1:0]     pos,
  output logic [N_LEDS-1:0] leds
);

  typedef enum logic [1:0] {M_ROT = 2'd0, M_BOUNCE = 2'd1, M_FILL = 2'd2, M_BLINK = 2'd3} mode_e;

  localparam logic [PW-1:0] LAST  = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] RST_P = PW'(RESET_POS);

  function automatic logic [N_LEDS-1:0] onehot(input logic [PW-1:0] p);
    logic [N_LEDS-1:0] m;
    for (int i = 0; i < N_LEDS; i++) m[i] = (PW'(i) == p);
    return m;
  endfunction

  // Bar lit from the starting end (bit 0 for dir=0, MSB for dir=1) through p.
  function automatic logic [N_LEDS-1:0] fill_mask(input logic [PW-1:0] p, input logic d);
    logic [N_LEDS-1:0] m;
    for (int i = 0; i < N_LEDS; i++) m[i] = d ? (PW'(i) >= p) : (PW'(i) <= p);
    return m;
  endfunction

  logic [DIV_W-1:0]  div_cnt;
  logic [N_LEDS-1:0] pat, pat_n;
  logic [PW-1:0]     pos_n, pos_inc, pos_dec;
  logic              up, up_n, up_eff, phase, phase_n, tick;
  mode_e             mode_q;

  // >= (not ==) lets a counter stranded above a lowered div_load wrap at once.
  assign tick    = enable && (div_cnt >= div_load);
  assign pos_inc = (pos == LAST) ? '0 : pos + 1'b1;
  assign pos_dec = (pos == '0) ? LAST : pos - 1'b1;
  // Entering bounce from another mode always starts upward.
  assign up_eff  = (mode_q == M_BOUNCE) ? up : 1'b1;

  always_comb begin
    pos_n   = pos;
    up_n    = up;
    phase_n = phase;
    pat_n   = pat;
    case (mode_e'(mode))
      M_ROT: begin
        pos_n = dir ? pos_dec : pos_inc;
        pat_n = onehot(pos_n);
      end
      M_BOUNCE: begin
        if (up_eff) begin
          if (pos == LAST) begin pos_n = pos_dec; up_n = 1'b0; end
          else             begin pos_n = pos_inc; up_n = 1'b1; end
        end else begin
          if (pos == '0)   begin pos_n = pos_inc; up_n = 1'b1; end
          else             begin pos_n = pos_dec; up_n = 1'b0; end
        end
        pat_n = onehot(pos_n);
      end
      M_FILL: begin
        pos_n = dir ? pos_dec : pos_inc;
        pat_n = fill_mask(pos_n, dir);
      end
      default: begin
        phase_n = ~phase;
        pat_n   = {N_LEDS{phase_n}};
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      pos     <= RST_P;
      pat     <= onehot(RST_P);
      step    <= 1'b0;
      up      <= 1'b1;
      phase   <= 1'b0;
      mode_q  <= M_ROT;
    end else begin
      step <= tick;
      if (enable) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        pos    <= pos_n;
        pat    <= pat_n;
        up     <= up_n;
        phase  <= phase_n;
        mode_q <= mode_e'(mode);
      end
    end
  end

`ifdef LED_FSM_PWM_EN
  logic [3:0] pwm_cnt, pwm_nxt;
  logic       pwm_on_n;

  assign pwm_nxt  = pwm_cnt + 4'd1;
  assign pwm_on_n = (pwm_nxt < brightness);

  // Gate is computed from next-cycle values so leds stay aligned with pos/step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      leds    <= onehot(RST_P);
    end else begin
      pwm_cnt <= pwm_nxt;
      leds    <= (tick ? pat_n : pat) & {N_LEDS{pwm_on_n}};
    end
  end
`else
  assign leds = pat;
`endif

endmodule

// File: tb/tb_led_pattern_fsm.sv
// Self-checking bench: 4-LED and 8-LED instances share stimulus; each vector checks one of them.
module tb_led_pattern_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        dir = 1'b0;
  logic [23:0] div_load = '0;

  logic       step4, step8;
  logic [1:0] pos4;
  logic [2:0] pos8;
  logic [3:0] leds4;
  logic [7:0] leds8;

  always #5 clk = ~clk;

  led_pattern_fsm #(.N_LEDS(4), .DIV_W(24), .RESET_POS(0)) u4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .dir(dir),
    .div_load(div_load), .step(step4), .pos(pos4), .leds(leds4));

  led_pattern_fsm #(.N_LEDS(8), .DIV_W(24), .RESET_POS(0)) u8 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .dir(dir),
    .div_load(div_load), .step(step8), .pos(pos8), .leds(leds8));

  typedef struct {
    bit          rst;   // hold reset through this cycle, expect reset values
    bit          sel;   // 0: 4-LED instance, 1: 8-LED instance
    bit          en;
    logic [1:0]  md;
    bit          dr;
    logic [23:0] dv;
    bit          e_step;
    int          e_pos;
    int          e_leds;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(bit rst, bit sel, bit en, logic [1:0] md, bit dr, int dv,
                              bit st, int p, int l);
    vec_t v;
    v.rst = rst; v.sel = sel; v.en = en; v.md = md; v.dr = dr; v.dv = 24'(dv);
    v.e_step = st; v.e_pos = p; v.e_leds = l;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_vec(input int idx, input vec_t e);
    if (e.sel) begin
      chk($sformatf("v%0d_step8", idx), int'(step8), int'(e.e_step));
      chk($sformatf("v%0d_pos8", idx),  int'(pos8),  e.e_pos);
      chk($sformatf("v%0d_leds8", idx), int'(leds8), e.e_leds);
    end else begin
      chk($sformatf("v%0d_step4", idx), int'(step4), int'(e.e_step));
      chk($sformatf("v%0d_pos4", idx),  int'(pos4),  e.e_pos);
      chk($sformatf("v%0d_leds4", idx), int'(leds4), e.e_leds);
    end
  endtask

  initial begin
    vec_t e;

    // 4 LEDs, rotate up, tick every cycle
    add(1,0, 1,0,0,0, 0,0,'h1);
    add(0,0, 1,0,0,0, 1,1,'h2);
    add(0,0, 1,0,0,0, 1,2,'h4);
    add(0,0, 1,0,0,0, 1,3,'h8);
    add(0,0, 1,0,0,0, 1,0,'h1);
    // 8 LEDs, rotate down, tick every 4th cycle, wrap 0 -> 7
    add(1,1, 1,0,1,3, 0,0,'h01);
    add(0,1, 1,0,1,3, 0,0,'h01);
    add(0,1, 1,0,1,3, 0,0,'h01);
    add(0,1, 1,0,1,3, 0,0,'h01);
    add(0,1, 1,0,1,3, 1,7,'h80);
    add(0,1, 1,0,1,3, 0,7,'h80);
    add(0,1, 1,0,1,3, 0,7,'h80);
    add(0,1, 1,0,1,3, 0,7,'h80);
    add(0,1, 1,0,1,3, 1,6,'h40);
    // 4 LEDs, bounce; dir flipped halfway must be ignored
    add(1,0, 1,1,0,0, 0,0,'h1);
    add(0,0, 1,1,0,0, 1,1,'h2);
    add(0,0, 1,1,0,0, 1,2,'h4);
    add(0,0, 1,1,0,0, 1,3,'h8);
    add(0,0, 1,1,0,0, 1,2,'h4);
    add(0,0, 1,1,1,0, 1,1,'h2);
    add(0,0, 1,1,1,0, 1,0,'h1);
    add(0,0, 1,1,1,0, 1,1,'h2);
    add(0,0, 1,1,1,0, 1,2,'h4);
    // 8 LEDs, fill up every 2 cycles, 5-cycle pause, wrap back to one LED
    add(1,1, 1,2,0,1, 0,0,'h01);
    add(0,1, 1,2,0,1, 0,0,'h01);
    add(0,1, 1,2,0,1, 1,1,'h03);
    add(0,1, 1,2,0,1, 0,1,'h03);
    add(0,1, 1,2,0,1, 1,2,'h07);
    add(0,1, 1,2,0,1, 0,2,'h07);
    add(0,1, 1,2,0,1, 1,3,'h0F);
    for (int k = 0; k < 5; k++) add(0,1, 0,2,0,1, 0,3,'h0F);
    add(0,1, 1,2,0,1, 0,3,'h0F);
    add(0,1, 1,2,0,1, 1,4,'h1F);
    add(0,1, 1,2,0,1, 0,4,'h1F);
    add(0,1, 1,2,0,1, 1,5,'h3F);
    add(0,1, 1,2,0,1, 0,5,'h3F);
    add(0,1, 1,2,0,1, 1,6,'h7F);
    add(0,1, 1,2,0,1, 0,6,'h7F);
    add(0,1, 1,2,0,1, 1,7,'hFF);
    add(0,1, 1,2,0,1, 0,7,'hFF);
    add(0,1, 1,2,0,1, 1,0,'h01);
    // 8 LEDs, fill down: bar grows from the MSB end
    add(1,1, 1,2,1,0, 0,0,'h01);
    add(0,1, 1,2,1,0, 1,7,'h80);
    add(0,1, 1,2,1,0, 1,6,'hC0);
    add(0,1, 1,2,1,0, 1,5,'hE0);
    // 8 LEDs, blink every 3 cycles
    add(1,1, 1,3,0,2, 0,0,'h01);
    add(0,1, 1,3,0,2, 0,0,'h01);
    add(0,1, 1,3,0,2, 0,0,'h01);
    add(0,1, 1,3,0,2, 1,0,'hFF);
    add(0,1, 1,3,0,2, 0,0,'hFF);
    add(0,1, 1,3,0,2, 0,0,'hFF);
    add(0,1, 1,3,0,2, 1,0,'h00);
    // 8 LEDs: div_load lowered under the running count, then mode changes keep pos
    add(1,1, 1,0,0,5, 0,0,'h01);
    for (int k = 0; k < 4; k++) add(0,1, 1,0,0,5, 0,0,'h01);
    add(0,1, 1,0,0,1, 1,1,'h02);
    add(0,1, 1,0,0,1, 0,1,'h02);
    add(0,1, 1,0,0,1, 1,2,'h04);
    add(0,1, 1,1,0,0, 1,3,'h08);
    add(0,1, 1,1,0,0, 1,4,'h10);
    add(0,1, 1,2,0,0, 1,5,'h3F);

    repeat (2) @(posedge clk);
    @(negedge clk);
    foreach (vecs[i]) begin
      enable = vecs[i].en; mode = vecs[i].md; dir = vecs[i].dr; div_load = vecs[i].dv;
      if (vecs[i].rst) reset_n = 1'b0;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      cmp_vec(i, e);
      @(negedge clk);
      reset_n = 1'b1;
    end

    // Async reset mid blink period: outputs must clear before the next edge.
    reset_n = 1'b0; mode = 2'd3; div_load = 24'd2; enable = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("blink_on_before_rst", int'(leds8), 'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_leds8", int'(leds8), 'h01);
    chk("async_rst_pos8",  int'(pos8),  0);
    chk("async_rst_leds4", int'(leds4), 'h1);
    @(negedge clk);
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
